// File: rtl/mem_io_responder.sv
// Responder side of the CPU byte bus: 128 KB RAM, UART TX FIFO, RX port, cycle counter, stop flag.
// Optional RX path compiled in with `define MEM_IO_RX_EN (default: reads of 0x30000 return 0x00).
module mem_io_responder #(
   parameter int ADDR_WIDTH    = 17,
   parameter int TX_DEPTH_LOG2 = 4,
   parameter int FULL_MARGIN   = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_pop,
   output logic        program_stop,
   output logic        tx_overflow
);
   localparam int DEPTH = 1 << TX_DEPTH_LOG2;
   localparam int CW    = TX_DEPTH_LOG2 + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] MARGIN_C = CW'(FULL_MARGIN);

   typedef enum logic [1:0] {SRC_HOLD, SRC_RAM, SRC_IO} rd_src_e;

   // bus decode
   logic                  is_io;
   logic [15:0]           io_off;
   logic [ADDR_WIDTH-1:0] ram_idx;
   logic                  ram_we, ram_re, io_wr, io_rd;

   assign is_io   = (mem_a[17:16] == 2'b11);
   assign io_off  = mem_a[15:0];
   assign ram_idx = mem_a[ADDR_WIDTH-1:0];
   assign ram_we  = mem_wr & ~is_io;
   assign ram_re  = ~mem_wr & ~is_io;
   assign io_wr   = mem_wr & is_io;
   assign io_rd   = ~mem_wr & is_io;

   // RAM: contents survive reset, read is registered every cycle
   logic [7:0] ram [0:(1<<ADDR_WIDTH)-1];
   logic [7:0] ram_rdata_q;

   always_ff @(posedge clk_in) begin
      if (ram_we) ram[ram_idx] <= mem_dout;
      ram_rdata_q <= ram[ram_idx];
   end

   // RX port
   logic       rx_hit;
   logic [7:0] rx_byte;
   logic       unused_bits;
`ifdef MEM_IO_RX_EN
   assign rx_hit      = io_rd & (io_off == 16'h0000) & rx_valid;
   assign rx_byte     = rx_data;
   assign rx_pop      = rx_hit & ~rst_in;
   assign unused_bits = ^mem_a[31:18];
`else
   assign rx_hit      = 1'b0;
   assign rx_byte     = 8'h00;
   assign rx_pop      = 1'b0;
   assign unused_bits = ^{mem_a[31:18], rx_data, rx_valid};
`endif

   // registers
   logic [31:0]              cnt_q, cnt_d;
   logic [31:0]              snap_q, snap_d;
   logic [7:0]               io_rdata_q, io_rdata_d;
   logic [7:0]               hold_q, hold_d;
   rd_src_e                  rd_src_q, rd_src_d;
   logic [TX_DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]            count_q, count_d, free_d;
   logic                     full_q, full_d;
   logic                     stop_q, stop_d;
   logic                     ovf_q, ovf_d;

   logic [7:0] fifo_mem [0:DEPTH-1];
   logic       push, push_ok, pop;
   logic [7:0] push_byte;

   // read data path and counter
   always_comb begin
      cnt_d      = cnt_q + 32'd1;
      snap_d     = snap_q;
      io_rdata_d = 8'h00;
      case (io_off)
         16'h0000: io_rdata_d = rx_hit ? rx_byte : 8'h00;
         16'h0004: io_rdata_d = cnt_q[7:0];
         16'h0005: io_rdata_d = snap_q[15:8];
         16'h0006: io_rdata_d = snap_q[23:16];
         16'h0007: io_rdata_d = snap_q[31:24];
         default:  io_rdata_d = 8'h00;
      endcase
      if (io_rd && io_off == 16'h0004) snap_d = cnt_q;
      if (ram_re)     rd_src_d = SRC_RAM;
      else if (io_rd) rd_src_d = SRC_IO;
      else            rd_src_d = SRC_HOLD;
   end

   // write cycles replay the last visible byte so mem_din holds across them
   always_comb begin
      case (rd_src_q)
         SRC_RAM: mem_din = ram_rdata_q;
         SRC_IO:  mem_din = io_rdata_q;
         default: mem_din = hold_q;
      endcase
      hold_d = mem_din;
   end

   // TX FIFO control
   always_comb begin
      push      = 1'b0;
      push_byte = mem_dout;
      stop_d    = stop_q;
      if (io_wr && io_off == 16'h0000 && mem_dout != 8'h00) push = 1'b1;
      if (io_wr && io_off == 16'h0004) begin
         push      = 1'b1;
         push_byte = 8'h00;
         stop_d    = 1'b1;
      end
      pop     = tx_valid & tx_ready;
      // a simultaneous pop frees the slot, so a full FIFO still accepts
      push_ok = push & ((count_q != DEPTH_C) | pop);
      ovf_d   = ovf_q | (push & ~push_ok);
      wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
      rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
      count_d = count_q;
      if (push_ok && !pop)      count_d = count_q + 1'b1;
      else if (!push_ok && pop) count_d = count_q - 1'b1;
      free_d  = DEPTH_C - count_d;
      full_d  = (free_d <= MARGIN_C);
   end

   always_ff @(posedge clk_in) begin
      if (push_ok) fifo_mem[wptr_q] <= push_byte;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt_q      <= '0;
         snap_q     <= '0;
         io_rdata_q <= '0;
         hold_q     <= '0;
         rd_src_q   <= SRC_HOLD;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         stop_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         snap_q     <= snap_d;
         io_rdata_q <= io_rdata_d;
         hold_q     <= hold_d;
         rd_src_q   <= rd_src_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         stop_q     <= stop_d;
         ovf_q      <= ovf_d;
      end
   end

   assign tx_valid       = (count_q != '0);
   assign tx_data        = fifo_mem[rptr_q];
   assign io_buffer_full = full_q;
   assign program_stop   = stop_q;
   assign tx_overflow    = ovf_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized bench for mem_io_responder against a queue/associative-array model of the bus map.
// Honours `define MEM_IO_RX_EN the same way the design does.
module tb_mem_io_responder;
   localparam int DEPTH  = 16;
   localparam int MARGIN = 2;
`ifdef MEM_IO_RX_EN
   localparam bit RX_EN = 1'b1;
`else
   localparam bit RX_EN = 1'b0;
`endif
   localparam logic [31:0] IO_TX   = 32'h0003_0000;
   localparam logic [31:0] IO_STOP = 32'h0003_0004;
   localparam logic [31:0] IDLE    = 32'h0003_0010;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_pop;
   logic        program_stop;
   logic        tx_overflow;

   mem_io_responder dut (
      .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_dout(mem_dout),
      .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
      .program_stop(program_stop), .tx_overflow(tx_overflow)
   );

   always #5 clk_in = ~clk_in;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model
   logic [7:0]  m_ram [int];
   logic [7:0]  m_q [$];
   int          wlist [$];
   logic [31:0] m_cyc;
   logic [31:0] m_snap;
   logic [7:0]  exp_din;
   bit          din_known;
   bit          m_stop, m_ovf;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_cyc     = '0;
      m_snap    = '0;
      exp_din   = 8'h00;
      din_known = 1'b1;
      m_stop    = 1'b0;
      m_ovf     = 1'b0;
   endtask

   // one bus cycle: drive, predict, clock, compare
   task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d, input logic rdy);
      logic        io, exp_pop, push;
      logic [15:0] off;
      logic [7:0]  pb;
      int          idx;
      mem_a = a; mem_wr = wr; mem_dout = d; tx_ready = rdy;
      #1;
      io      = (a[17:16] == 2'b11);
      off     = a[15:0];
      idx     = int'(a[16:0]);
      exp_pop = RX_EN && io && !wr && off == 16'h0000 && rx_valid;
      chk("rx_pop", {31'b0, rx_pop}, {31'b0, exp_pop});
      if (!wr) begin
         if (!io) begin
            din_known = m_ram.exists(idx);
            if (din_known) exp_din = m_ram[idx];
         end else begin
            din_known = 1'b1;
            case (off)
               16'h0000: exp_din = exp_pop ? rx_data : 8'h00;
               16'h0004: begin exp_din = m_cyc[7:0]; m_snap = m_cyc; end
               16'h0005: exp_din = m_snap[15:8];
               16'h0006: exp_din = m_snap[23:16];
               16'h0007: exp_din = m_snap[31:24];
               default:  exp_din = 8'h00;
            endcase
         end
      end
      push = io && wr && ((off == 16'h0000 && d != 8'h00) || off == 16'h0004);
      pb   = (off == 16'h0004) ? 8'h00 : d;
      if (io && wr && off == 16'h0004) m_stop = 1'b1;
      if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
      if (push) begin
         if (m_q.size() < DEPTH) m_q.push_back(pb);
         else m_ovf = 1'b1;
      end
      if (wr && !io) begin
         m_ram[idx] = d;
         wlist.push_back(idx);
      end
      @(posedge clk_in);
      #1;
      m_cyc = m_cyc + 1;
      if (din_known) chk("mem_din", {24'b0, mem_din}, {24'b0, exp_din});
      chk("tx_valid", {31'b0, tx_valid}, {31'b0, m_q.size() != 0});
      if (m_q.size() != 0) chk("tx_data", {24'b0, tx_data}, {24'b0, m_q[0]});
      chk("io_buffer_full", {31'b0, io_buffer_full}, {31'b0, (DEPTH - m_q.size()) <= MARGIN});
      chk("program_stop", {31'b0, program_stop}, {31'b0, m_stop});
      chk("tx_overflow", {31'b0, tx_overflow}, {31'b0, m_ovf});
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cyc(IDLE, 1'b0, 8'h00, 1'b1);
   endtask

   function automatic logic [31:0] io_addr(input logic [15:0] off);
      logic [31:0] a;
      a = $urandom;
      a[17:16] = 2'b11;
      a[15:0]  = off;
      return a;
   endfunction

   initial begin
      logic [7:0]  b0, b1, b2, b3;
      logic [31:0] n_exp, a;
      int          r, idx;

      rst_in = 1'b1; mem_a = IDLE; mem_wr = 1'b0; mem_dout = 8'h00;
      tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
      model_reset();
      repeat (3) @(posedge clk_in);
      #1;
      chk("rst_mem_din", {24'b0, mem_din}, 32'h0);
      chk("rst_full", {31'b0, io_buffer_full}, 32'h0);
      chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
      chk("rst_rx_pop", {31'b0, rx_pop}, 32'h0);
      chk("rst_stop", {31'b0, program_stop}, 32'h0);
      chk("rst_ovf", {31'b0, tx_overflow}, 32'h0);
      rst_in = 1'b0;

      // RAM write, read-after-write, unwritten neighbour, re-read
      cyc(32'h0000_0100, 1'b1, 8'hA5, 1'b0);
      cyc(32'h0000_0100, 1'b0, 8'h00, 1'b0);
      chk("raw_a5", {24'b0, mem_din}, 32'hA5);
      cyc(32'h0000_0101, 1'b0, 8'h00, 1'b0);
      cyc(32'h0000_0100, 1'b0, 8'h00, 1'b0);
      cyc(32'h0000_0200, 1'b1, 8'h3C, 1'b0);
      chk("din_hold_on_write", {24'b0, mem_din}, 32'hA5);

      // single TX push, then a zero byte that must be ignored
      cyc(IO_TX, 1'b1, 8'h41, 1'b0);
      chk("tx_41", {24'b0, tx_data}, 32'h41);
      cyc(IO_TX, 1'b1, 8'h00, 1'b0);
      drain(1);
      chk("tx_empty_after_one", {31'b0, tx_valid}, 32'h0);

      // fill to the margin, overflow on the 17th, drain in order
      for (int i = 1; i <= 17; i++) begin
         cyc(IO_TX, 1'b1, 8'(8'h10 + i), 1'b0);
         if (i == 13) chk("full_at_13", {31'b0, io_buffer_full}, 32'h0);
         if (i == 14) chk("full_at_14", {31'b0, io_buffer_full}, 32'h1);
         if (i == 16) chk("ovf_at_16", {31'b0, tx_overflow}, 32'h0);
      end
      chk("ovf_at_17", {31'b0, tx_overflow}, 32'h1);
      drain(16);
      chk("drained_valid", {31'b0, tx_valid}, 32'h0);
      chk("drained_full", {31'b0, io_buffer_full}, 32'h0);

      // program stop and counter snapshot
      cyc(IO_STOP, 1'b1, 8'h5A, 1'b0);
      chk("stop_set", {31'b0, program_stop}, 32'h1);
      chk("stop_byte", {24'b0, tx_data}, 32'h0);
      drain(1);
      n_exp = m_cyc;
      cyc(io_addr(16'h0004), 1'b0, 8'h00, 1'b0); b0 = mem_din;
      cyc(io_addr(16'h0005), 1'b0, 8'h00, 1'b0); b1 = mem_din;
      cyc(io_addr(16'h0006), 1'b0, 8'h00, 1'b0); b2 = mem_din;
      cyc(io_addr(16'h0007), 1'b0, 8'h00, 1'b0); b3 = mem_din;
      chk("snap_reasm", {b3, b2, b1, b0}, n_exp);

      // RX port
      rx_valid = 1'b1; rx_data = 8'h37;
      cyc(IO_TX, 1'b0, 8'h00, 1'b0);
      chk("rx_37", {24'b0, mem_din}, RX_EN ? 32'h37 : 32'h0);
      rx_valid = 1'b0;
      cyc(IO_TX, 1'b0, 8'h00, 1'b0);
      chk("rx_none", {24'b0, mem_din}, 32'h0);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         rx_valid = 1'($urandom_range(0, 1));
         rx_data  = 8'($urandom);
         r = $urandom_range(0, 99);
         if (r < 25 || (r < 50 && wlist.size() == 0)) begin
            idx = $urandom_range(0, 255) | ($urandom_range(0, 1) << 16);
            a = $urandom;
            a[16:0] = 17'(idx);
            a[17] = (idx >= 32'h10000) ? 1'b0 : 1'($urandom_range(0, 1));
            cyc(a, 1'b1, 8'($urandom), 1'($urandom_range(0, 9) < 4));
         end else if (r < 50) begin
            idx = wlist[$urandom_range(0, wlist.size() - 1)];
            a = $urandom;
            a[16:0] = 17'(idx);
            a[17] = (idx >= 32'h10000) ? 1'b0 : 1'($urandom_range(0, 1));
            cyc(a, 1'b0, 8'h00, 1'($urandom_range(0, 9) < 4));
         end else if (r < 65) begin
            cyc(io_addr(16'h0000), 1'b1, ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom),
                1'($urandom_range(0, 9) < 4));
         end else if (r < 68) begin
            cyc(io_addr(16'($urandom_range(8, 16'hFFFF))), 1'b1, 8'($urandom), 1'($urandom_range(0, 1)));
         end else if (r < 70) begin
            cyc(io_addr(16'h0004), 1'b1, 8'($urandom), 1'($urandom_range(0, 1)));
         end else if (r < 85) begin
            cyc(io_addr((r < 78) ? 16'h0000 : 16'(3 + $urandom_range(1, 4))), 1'b0, 8'h00,
                1'($urandom_range(0, 9) < 4));
         end else begin
            cyc(io_addr(16'($urandom_range(8, 16'hFFFF))), 1'b0, 8'h00, 1'($urandom_range(0, 1)));
         end
      end

      // asynchronous reset with 5 bytes queued and read data in flight
      rx_valid = 1'b0;
      drain(DEPTH + 1);
      for (int i = 0; i < 5; i++) cyc(IO_TX, 1'b1, 8'(8'h61 + i), 1'b0);
      cyc(IO_STOP, 1'b1, 8'h00, 1'b0);
      cyc(32'h0000_0100, 1'b0, 8'h00, 1'b0);
      chk("pre_rst_din", {24'b0, mem_din}, 32'hA5);
      #2;
      rst_in = 1'b1;
      #1;
      chk("arst_tx_valid", {31'b0, tx_valid}, 32'h0);
      chk("arst_full", {31'b0, io_buffer_full}, 32'h0);
      chk("arst_stop", {31'b0, program_stop}, 32'h0);
      chk("arst_ovf", {31'b0, tx_overflow}, 32'h0);
      chk("arst_mem_din", {24'b0, mem_din}, 32'h0);
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      model_reset();
      cyc(32'h0000_0100, 1'b0, 8'h00, 1'b0);
      chk("ram_kept", {24'b0, mem_din}, 32'hA5);
      cyc(io_addr(16'h0004), 1'b0, 8'h00, 1'b0);
      chk("cnt_restart", {24'b0, mem_din}, 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
